// File: rtl/instr_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
// Package "core" holds the format codes, the input field bundle, the NOP
// word and the signed immediate limits used by the range checks.
package core;

    // Instruction format codes; 3'd6 and 3'd7 are deliberately not members.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } formats_t;

    // One decoded instruction as presented on the input side.
    typedef struct packed {
        formats_t    format;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } enc_fields_t;

    // addi x0, x0, 0 -- emitted in place of an unencodable format.
    localparam logic [31:0] NOP = 32'h0000_0013;

    // Signed limits of the immediates each format can carry.
    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    // True when the two's-complement immediate lies inside [lo, hi].
    function automatic logic imm_in_range(input logic [31:0] imm,
                                          input int lo, input int hi);
        return ($signed(imm) >= lo) && ($signed(imm) <= hi);
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Bundle of the encoder's input field handshake and output word handshake.
// The slave modport is the encoder itself; master is whoever drives fields
// in and collects words out.
interface instr_encoder_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    // Input field handshake
    logic              in_valid_i;
    logic              in_ready_o;
    logic [2:0]        format_i;
    logic [6:0]        opcode_i;
    logic [4:0]        rd_i;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic [2:0]        funct3_i;
    logic [6:0]        funct7_i;
    logic [31:0]       imm_i;

    // Output word handshake and status
    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       instr_o;
    logic [ADDR_W-1:0] out_addr_o;
    logic              err_o;
    logic [CNT_W-1:0]  instr_cnt_o;
    logic [CNT_W-1:0]  err_cnt_o;

    modport master (
        output in_valid_i, format_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, out_addr_o, err_o,
               instr_cnt_o, err_cnt_o
    );

    modport slave (
        input  in_valid_i, format_i, opcode_i, rd_i, rs1_i, rs2_i,
               funct3_i, funct7_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, instr_o, out_addr_o, err_o,
               instr_cnt_o, err_cnt_o
    );

endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: purely combinational RV32I field packer.
// Places register, funct and immediate bits into their format-specific
// positions and flags immediates that do not fit the format. An out-of-range
// immediate is still packed from its truncated bits so the word is
// deterministic; only err says it is wrong.
module instr_pack
    import core::*;
(
    input  enc_fields_t fields_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    logic [31:0] imm;
    assign imm = fields_i.imm;

    // Pack the word for the selected format and evaluate its immediate range.
    always_comb begin
        instr_o = NOP;
        err_o   = 1'b0;
        case (fields_i.format)
            FMT_R: begin
                instr_o = {fields_i.funct7, fields_i.rs2, fields_i.rs1,
                           fields_i.funct3, fields_i.rd, fields_i.opcode};
                err_o   = 1'b0;
            end
            FMT_I: begin
                instr_o = {imm[11:0], fields_i.rs1, fields_i.funct3,
                           fields_i.rd, fields_i.opcode};
                err_o   = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_S: begin
                instr_o = {imm[11:5], fields_i.rs2, fields_i.rs1,
                           fields_i.funct3, imm[4:0], fields_i.opcode};
                err_o   = !imm_in_range(imm, IMM12_MIN, IMM12_MAX);
            end
            FMT_B: begin
                instr_o = {imm[12], imm[10:5], fields_i.rs2, fields_i.rs1,
                           fields_i.funct3, imm[4:1], imm[11], fields_i.opcode};
                // Branch targets are halfword aligned, so bit 0 must be clear.
                err_o   = !imm_in_range(imm, IMM_B_MIN, IMM_B_MAX) || imm[0];
            end
            FMT_U: begin
                instr_o = {imm[31:12], fields_i.rd, fields_i.opcode};
                // U carries the full upper value; low 12 bits cannot be encoded.
                err_o   = |imm[11:0];
            end
            FMT_J: begin
                instr_o = {imm[20], imm[10:1], imm[11], imm[19:12],
                           fields_i.rd, fields_i.opcode};
                err_o   = !imm_in_range(imm, IMM_J_MIN, IMM_J_MAX) || imm[0];
            end
            default: begin
                // Codes 6 and 7 have no encoding.
                instr_o = NOP;
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage streaming RV32I instruction encoder.
// S1 captures the field bundle; instr_pack turns S1 into {word, err}; S2
// holds the packed word with its write address until the consumer takes it.
// Both stages can be full at once, and S2 can drain while S1 refills in the
// same cycle, so a continuously ready consumer sees one word per cycle.
// Optional build macro ENC_DROP_ERR_EN: erroneous bundles are discarded at
// the S1->S2 transfer (counted in err_cnt_o only) and err_o reads 0.
module instr_encoder
    import core::*;
#(
    parameter int                ADDR_W    = 32,
    // First address after reset; expected to be a multiple of 4.
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                CNT_W     = 16
)(
    input  logic             clk_i,
    input  logic             rst_i,
    instr_encoder_if.slave   bus
);

    // Stage 1: captured field bundle
    logic              s1_valid_q, s1_valid_d;
    enc_fields_t       s1_fields_q, s1_fields_d;

    // Stage 2: packed word presented on the output
    logic              out_valid_q, out_valid_d;
    logic [31:0]       instr_q, instr_d;
    logic              err_q, err_d;

    // Address and statistics
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  instr_cnt_q, instr_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

    // Handshake decode
    logic              s2_ready;
    logic              in_ready;
    logic              in_fire;
    logic              s1_xfer;
    logic              out_fire;
    logic              drop_xfer;
    logic              load_s2;

    enc_fields_t       fields_in;
    logic [31:0]       pack_instr;
    logic              pack_err;

    // Gather the loose input fields into one bundle.
    always_comb begin
        fields_in        = '0;
        fields_in.format = formats_t'(bus.format_i);
        fields_in.opcode = bus.opcode_i;
        fields_in.rd     = bus.rd_i;
        fields_in.rs1    = bus.rs1_i;
        fields_in.rs2    = bus.rs2_i;
        fields_in.funct3 = bus.funct3_i;
        fields_in.funct7 = bus.funct7_i;
        fields_in.imm    = bus.imm_i;
    end

    instr_pack u_pack (
        .fields_i (s1_fields_q),
        .instr_o  (pack_instr),
        .err_o    (pack_err)
    );

    // Handshake terms; in_ready depends combinationally on out_ready_i so
    // S1 can refill in the same cycle S2 drains.
    always_comb begin
        s2_ready = !out_valid_q || bus.out_ready_i;
        in_ready = !s1_valid_q || s2_ready;
        in_fire  = bus.in_valid_i && in_ready;
        s1_xfer  = s1_valid_q && s2_ready;
        out_fire = out_valid_q && bus.out_ready_i;
`ifdef ENC_DROP_ERR_EN
        drop_xfer = s1_xfer && pack_err;
`else
        drop_xfer = 1'b0;
`endif
        load_s2  = s1_xfer && !drop_xfer;
    end

    // Next-state for both pipeline stages.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_fields_d = s1_fields_q;
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        err_d       = err_q;

        if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_fields_d = fields_in;
        end else if (s1_xfer) begin
            s1_valid_d  = 1'b0;
        end

        // Loading S2 takes priority: a drain and a refill in the same cycle
        // simply replaces the word.
        if (load_s2) begin
            out_valid_d = 1'b1;
            instr_d     = pack_instr;
`ifdef ENC_DROP_ERR_EN
            err_d       = 1'b0;
`else
            err_d       = pack_err;
`endif
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Next-state for the address and the wrapping counters.
    always_comb begin
        addr_d      = addr_q;
        instr_cnt_d = instr_cnt_q;
        err_cnt_d   = err_cnt_q;

        if (out_fire) begin
            addr_d      = addr_q + ADDR_W'(4);
            instr_cnt_d = instr_cnt_q + CNT_W'(1);
        end
`ifdef ENC_DROP_ERR_EN
        // Dropped bundles are counted when they leave S1.
        if (drop_xfer) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
`else
        if (out_fire && err_q) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
`endif
    end

    // State registers; reset empties both stages and discards in-flight data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_fields_q <= '0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            err_q       <= 1'b0;
            addr_q      <= BASE_ADDR;
            instr_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fields_q <= s1_fields_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            err_q       <= err_d;
            addr_q      <= addr_d;
            instr_cnt_q <= instr_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.instr_o     = instr_q;
    assign bus.err_o       = err_q;
    assign bus.out_addr_o  = addr_q;
    assign bus.instr_cnt_o = instr_cnt_q;
    assign bus.err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder. A reference encoder built from
// plain shifts/masks and signed integer limits predicts every word; a queue
// of expected words is matched against each output handshake. Honours
// ENC_DROP_ERR_EN when the build defines it.
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'hFFFF_FFF8;
`ifdef ENC_DROP_ERR_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        bit          fixed;
        logic [31:0] xinstr;
        logic        xerr;
    } stim_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        bit          drop;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(32), .CNT_W(16)) bus ();

    instr_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    stim_t       stim_q[$];
    exp_t        sb_q[$];
    logic [31:0] exp_addr;
    logic [15:0] exp_icnt;
    logic [15:0] exp_ecnt;

    // Reference encoder: fields shifted into place, ranges as signed integers.
    function automatic void ref_encode(input stim_t s, output logic [31:0] w, output logic e);
        longint      v;
        logic [31:0] m, opw, rdw, f3w, r1w, r2w;
        v   = longint'($signed(s.imm));
        m   = s.imm;
        opw = 32'(s.op);
        rdw = 32'(s.rd) << 7;
        f3w = 32'(s.f3) << 12;
        r1w = 32'(s.rs1) << 15;
        r2w = 32'(s.rs2) << 20;
        case (s.fmt)
            3'd0: begin w = (32'(s.f7) << 25) | r2w | r1w | f3w | rdw | opw; e = 1'b0; end
            3'd1: begin
                w = ((m & 32'hFFF) << 20) | r1w | f3w | rdw | opw;
                e = (v < -2048) || (v > 2047);
            end
            3'd2: begin
                w = (((m >> 5) & 32'h7F) << 25) | r2w | r1w | f3w | ((m & 32'h1F) << 7) | opw;
                e = (v < -2048) || (v > 2047);
            end
            3'd3: begin
                w = (((m >> 12) & 32'h1) << 31) | (((m >> 5) & 32'h3F) << 25) | r2w | r1w | f3w
                  | (((m >> 1) & 32'hF) << 8) | (((m >> 11) & 32'h1) << 7) | opw;
                e = (v < -4096) || (v > 4094) || (m[0] == 1'b1);
            end
            3'd4: begin
                w = (m & 32'hFFFF_F000) | rdw | opw;
                e = (m & 32'hFFF) != 32'd0;
            end
            3'd5: begin
                w = (((m >> 20) & 32'h1) << 31) | (((m >> 1) & 32'h3FF) << 21)
                  | (((m >> 11) & 32'h1) << 20) | (m & 32'h000F_F000) | rdw | opw;
                e = (v < -1048576) || (v > 1048574) || (m[0] == 1'b1);
            end
            default: begin w = 32'h0000_0013; e = 1'b1; end
        endcase
    endfunction

    // Random bundle: legal immediates by default, corrupted with err_pct odds.
    function automatic stim_t rand_stim(input int err_pct);
        stim_t s;
        if (err_pct > 0 && $urandom_range(0, 9) == 0) s.fmt = 3'($urandom_range(6, 7));
        else                                          s.fmt = 3'($urandom_range(0, 5));
        s.op  = 7'($urandom);
        s.rd  = 5'($urandom);
        s.rs1 = 5'($urandom);
        s.rs2 = 5'($urandom);
        s.f3  = 3'($urandom);
        s.f7  = 7'($urandom);
        case (s.fmt)
            3'd1, 3'd2: s.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            3'd3:       s.imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            3'd4:       s.imm = $urandom & 32'hFFFF_F000;
            3'd5:       s.imm = (32'($urandom_range(0, 1048575)) - 32'h8_0000) << 1;
            default:    s.imm = $urandom;
        endcase
        if ($urandom_range(0, 99) < err_pct) begin
            if ($urandom_range(0, 1) == 1) s.imm = $urandom;
            else                           s.imm = s.imm ^ 32'd1;
        end
        s.fixed  = 1'b0;
        s.xinstr = 32'd0;
        s.xerr   = 1'b0;
        return s;
    endfunction

    task automatic drive_fields(input stim_t s);
        bus.format_i = s.fmt;
        bus.opcode_i = s.op;
        bus.rd_i     = s.rd;
        bus.rs1_i    = s.rs1;
        bus.rs2_i    = s.rs2;
        bus.funct3_i = s.f3;
        bus.funct7_i = s.f7;
        bus.imm_i    = s.imm;
    endtask

    function automatic stim_t mk(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                                 input logic [31:0] imm, input logic [31:0] xi, input logic xe);
        stim_t s;
        s.fmt = fmt; s.op = op; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.f3 = f3;
        s.f7 = 7'd0; s.imm = imm; s.fixed = 1'b1; s.xinstr = xi; s.xerr = xe;
        return s;
    endfunction

    // One reset edge; the model restarts from the reset state.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_addr = BASE;
        exp_icnt = '0;
        exp_ecnt = '0;
        sb_q.delete();
        stim_q.delete();
    endtask

    // Streams stim_q through the DUT, scoring each handshake until drained.
    task automatic run_stream(input string tag, input int rdy_pct, input int stall_start,
                              input int stall_len, input bit b2b, input bit check_gap);
        int          cyc, idle, last_fire;
        bit          hold_pend, has_drop, nondrop, exp_rdy;
        logic [31:0] h_instr, h_addr, w;
        logic        h_err, er;
        exp_t        e;
        stim_t       s;
        cyc = 0; idle = 0; last_fire = -1; hold_pend = 0;
        h_instr = '0; h_addr = '0; h_err = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc >= stall_start && cyc < stall_start + stall_len) bus.out_ready_i = 1'b0;
            else bus.out_ready_i = ($urandom_range(0, 99) < rdy_pct);
            if (stim_q.size() > 0 && (b2b || $urandom_range(0, 1) == 1)) begin
                drive_fields(stim_q[0]);
                bus.in_valid_i = 1'b1;
            end else begin
                drive_fields(rand_stim(0));
                bus.in_valid_i = 1'b0;
            end
            #1;
            if (hold_pend) begin
                checks++;
                if ({bus.out_valid_o, bus.instr_o, bus.out_addr_o, bus.err_o} !== {1'b1, h_instr, h_addr, h_err}) begin
                    errors++;
                    $display("FAIL %s hold_stable cyc=%0d: got v=%b instr=%h addr=%h err=%b want v=1 instr=%h addr=%h err=%b",
                             tag, cyc, bus.out_valid_o, bus.instr_o, bus.out_addr_o, bus.err_o, h_instr, h_addr, h_err);
                end
            end
            has_drop = 0;
            foreach (sb_q[k]) if (sb_q[k].drop) has_drop = 1;
            if (!has_drop) begin
                exp_rdy = !(sb_q.size() >= 2 && bus.out_ready_i == 1'b0);
                checks++;
                if (bus.in_ready_o !== exp_rdy) begin
                    errors++;
                    $display("FAIL %s in_ready cyc=%0d: got %b want %b (in flight %0d)",
                             tag, cyc, bus.in_ready_o, exp_rdy, sb_q.size());
                end
            end
            if (bus.out_valid_o === 1'b1 && bus.out_ready_i === 1'b1) begin
                while (sb_q.size() > 0 && sb_q[0].drop) void'(sb_q.pop_front());
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_word cyc=%0d: got instr=%h addr=%h want none",
                             tag, cyc, bus.instr_o, bus.out_addr_o);
                end else begin
                    e = sb_q.pop_front();
                    if ({bus.instr_o, bus.err_o, bus.out_addr_o} !== {e.instr, e.err, exp_addr}) begin
                        errors++;
                        $display("FAIL %s word cyc=%0d: got instr=%h err=%b addr=%h want instr=%h err=%b addr=%h",
                                 tag, cyc, bus.instr_o, bus.err_o, bus.out_addr_o, e.instr, e.err, exp_addr);
                    end
                end
                exp_addr = exp_addr + 32'd4;
                exp_icnt = exp_icnt + 16'd1;
                if (check_gap && last_fire >= 0) begin
                    checks++;
                    if (cyc - last_fire != 1) begin
                        errors++;
                        $display("FAIL %s throughput: got gap %0d want 1", tag, cyc - last_fire);
                    end
                end
                last_fire = cyc;
            end
            hold_pend = (bus.out_valid_o === 1'b1) && (bus.out_ready_i === 1'b0);
            h_instr = bus.instr_o; h_addr = bus.out_addr_o; h_err = bus.err_o;
            if (bus.in_valid_i === 1'b1 && bus.in_ready_o === 1'b1) begin
                s = stim_q.pop_front();
                if (s.fixed) begin w = s.xinstr; er = s.xerr; end
                else ref_encode(s, w, er);
                if (er) exp_ecnt = exp_ecnt + 16'd1;
                e.instr = w;
                e.err   = DROP ? 1'b0 : er;
                e.drop  = er && DROP;
                sb_q.push_back(e);
            end
            nondrop = 0;
            foreach (sb_q[k]) if (!sb_q[k].drop) nondrop = 1;
            if (stim_q.size() == 0 && !nondrop) idle++;
            else idle = 0;
            cyc++;
            if (idle >= 4) break;
            if (cyc >= 5000) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got %0d words pending want 0", tag, sb_q.size() + stim_q.size());
                break;
            end
        end
        bus.in_valid_i = 1'b0;
        sb_q.delete();
        stim_q.delete();
        checks++;
        if ({bus.instr_cnt_o, bus.err_cnt_o, bus.out_addr_o} !== {exp_icnt, exp_ecnt, exp_addr}) begin
            errors++;
            $display("FAIL %s counters: got icnt=%0d ecnt=%0d addr=%h want icnt=%0d ecnt=%0d addr=%h",
                     tag, bus.instr_cnt_o, bus.err_cnt_o, bus.out_addr_o, exp_icnt, exp_ecnt, exp_addr);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks += 7;
        if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid_o); end
        if (bus.instr_o !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", bus.instr_o); end
        if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err_o); end
        if (bus.out_addr_o !== BASE) begin errors++; $display("FAIL reset_addr: got %h want %h", bus.out_addr_o, BASE); end
        if (bus.instr_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_icnt: got %0d want 0", bus.instr_cnt_o); end
        if (bus.err_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_ecnt: got %0d want 0", bus.err_cnt_o); end
        if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
    endtask

    // addi x5, x6, -1 : accept at edge N, valid after edge N+1.
    task automatic test_latency();
        @(negedge clk);
        drive_fields(mk(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'd0, 1'b0));
        bus.in_valid_i  = 1'b1;
        bus.out_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL lat_accept: got in_ready=%b want 1", bus.in_ready_o); end
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL lat_early: got valid=%b want 0", bus.out_valid_o); end
        @(negedge clk);
        #1;
        checks++;
        if ({bus.out_valid_o, bus.instr_o, bus.err_o, bus.out_addr_o} !== {1'b1, 32'hFFF3_0293, 1'b0, BASE}) begin
            errors++;
            $display("FAIL lat_word: got v=%b instr=%h err=%b addr=%h want v=1 instr=fff30293 err=0 addr=%h",
                     bus.out_valid_o, bus.instr_o, bus.err_o, bus.out_addr_o, BASE);
        end
        @(negedge clk);
        #1;
        exp_addr = BASE + 32'd4;
        exp_icnt = 16'd1;
        checks++;
        if ({bus.out_valid_o, bus.instr_cnt_o, bus.out_addr_o} !== {1'b0, 16'd1, exp_addr}) begin
            errors++;
            $display("FAIL lat_after: got v=%b icnt=%0d addr=%h want v=0 icnt=1 addr=%h",
                     bus.out_valid_o, bus.instr_cnt_o, bus.out_addr_o, exp_addr);
        end
    endtask

    // sw x2, 8(x1) followed immediately by more words at full rate.
    task automatic test_back_to_back();
        stim_q.push_back(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020_A423, 1'b0));
        for (int i = 0; i < 6; i++) stim_q.push_back(rand_stim(0));
        run_stream("b2b", 100, -1, 0, 1'b1, 1'b1);
    endtask

    // addi x5, x6, 2048 does not fit 12 bits.
    task automatic test_err_imm();
        logic [15:0] ecnt0;
        do_reset();
        ecnt0 = bus.err_cnt_o;
        stim_q.push_back(mk(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'd2048, 32'h8003_0293, 1'b1));
        stim_q.push_back(mk(3'd1, 7'h13, 5'd5, 5'd6, 5'd0, 3'd0, 32'hFFFF_FFFF, 32'hFFF3_0293, 1'b0));
        run_stream("err_imm", 100, -1, 0, 1'b1, 1'b0);
        checks++;
        if (bus.err_cnt_o !== ecnt0 + 16'd1) begin
            errors++;
            $display("FAIL err_imm_cnt: got %0d want %0d", bus.err_cnt_o, ecnt0 + 16'd1);
        end
    endtask

    // Four words with the consumer stalled for three cycles.
    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 4; i++) stim_q.push_back(rand_stim(0));
        run_stream("stall", 100, 1, 3, 1'b1, 1'b0);
    endtask

    // Base FFFF_FFF8: the third word lands at 0 and the next address is 4.
    task automatic test_addr_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) stim_q.push_back(rand_stim(0));
        run_stream("wrap", 100, -1, 0, 1'b1, 1'b0);
        checks++;
        if (bus.out_addr_o !== 32'h0000_0004) begin
            errors++;
            $display("FAIL wrap_addr: got %h want 00000004", bus.out_addr_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) stim_q.push_back(rand_stim(25));
        run_stream("random", 70, 40, 6, 1'b0, 1'b0);
    endtask

    // Reset with both stages holding words: nothing may surface afterwards.
    task automatic test_reset_midflight();
        do_reset();
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        drive_fields(rand_stim(0));
        bus.in_valid_i = 1'b1;
        @(negedge clk);
        drive_fields(rand_stim(0));
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid_o, bus.in_ready_o} !== 2'b10) begin
            errors++;
            $display("FAIL mid_full: got valid=%b in_ready=%b want valid=1 in_ready=0", bus.out_valid_o, bus.in_ready_o);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid_o, bus.instr_cnt_o, bus.err_cnt_o, bus.out_addr_o} !== {1'b0, 16'd0, 16'd0, BASE}) begin
            errors++;
            $display("FAIL mid_reset: got v=%b icnt=%0d ecnt=%0d addr=%h want v=0 icnt=0 ecnt=0 addr=%h",
                     bus.out_valid_o, bus.instr_cnt_o, bus.err_cnt_o, bus.out_addr_o, BASE);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus.out_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_ghost cyc=%0d: got valid=%b instr=%h want valid=0", i, bus.out_valid_o, bus.instr_o);
            end
        end
        exp_addr = BASE;
        exp_icnt = '0;
        exp_ecnt = '0;
    endtask

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.format_i    = '0;
        bus.opcode_i    = '0;
        bus.rd_i        = '0;
        bus.rs1_i       = '0;
        bus.rs2_i       = '0;
        bus.funct3_i    = '0;
        bus.funct7_i    = '0;
        bus.imm_i       = '0;
        exp_addr = BASE;
        exp_icnt = '0;
        exp_ecnt = '0;
        repeat (2) @(posedge clk);
        test_reset();
        test_latency();
        test_back_to_back();
        test_err_imm();
        test_stall();
        test_addr_wrap();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
